iiitb_pwm_meas: RTL and testbench
=================================

Name: iiitb_pwm_meas

Overview:
PWM receiver/decoder: the measuring end of the iiitb_pwm_gen link. Samples an external PWM pad input and measures period and high time in clk cycles. Reports duty cycle in tenths (0..10), the same 10-step scale the generator uses. Sits in user_proj_example beside iiitb_pwm_gen, so the loopback io_out[35] -> io_in[34] is self-checking.

Parameters:
CNT_W, 16, width of the period/high counters and outputs
TIMEOUT, 1000, clk cycles without a rising edge before a stuck condition is declared; must be <= 2^CNT_W-1 and >= 16

Ports:
clk  input  1  system clock (wb_clk_i in user_proj_example)
reset_n  input  1  asynchronous, active-low reset
pwm_in  input  1  asynchronous PWM input from pad
period_o  output  CNT_W  last measured period, clk cycles
high_o  output  CNT_W  last measured high time, clk cycles
duty_o  output  4  floor(10*high_o/period_o); 10 or 0 on stuck
valid_o  output  1  one-cycle pulse when outputs update
stuck_o  output  1  input had no rising edge for TIMEOUT cycles
overrun_o  output  1  sticky: a capture was dropped during divide

Behaviour:
- Reset (reset_n=0, async): all outputs 0; sync flops 0; state IDLE; counters 0.
- Input sync: 2-flop synchronizer into s2, plus history flop s3. rise = s2 & ~s3. All logic uses s2 only.
- Counters: period_cnt counts clk cycles since the last rise. high_cnt counts cycles with s2=1 in the same window. Both restart on every rise. Both saturate at 2^CNT_W-1, with no wrap.
- Capture cycle: captured period = number of cycles between consecutive rise pulses. Captured high = number of cycles with s2=1 in that window.
  - Example: 10-cycle period, 5 cycles high -> period 10, high 5.
- States:
  - IDLE: waiting for the first rise. On rise, restart counters and go to MEASURE. No capture.
  - MEASURE: on rise (capture cycle C), latch period_cap/high_cap, restart counters, go to DIVIDE.
  - DIVIDE: cycles C+1..C+4. Restoring division of dividend 10*high_cap (CNT_W+4 bits, computed as 8h+2h) by period_cap, one quotient bit per cycle, MSB first (bit3..bit0).
    - At C+5: period_o, high_o and duty_o update; valid_o=1 for one cycle; stuck_o cleared; return to MEASURE.
    - A rise exactly at C+5 is a normal new capture.
- Counting continues during DIVIDE. A rise in C+1..C+4 restarts the counters but its capture is dropped and overrun_o is set. overrun_o clears only on reset. Minimum period measurable without overrun: 5 cycles.
- Quotient is floor. high_cap < period_cap always, so measured duty is 0..9. Duty 10 is reachable only via stuck-high.
- Timeout: in MEASURE or IDLE, when period_cnt reaches TIMEOUT with no rise:
  - Next cycle: duty_o = s2 ? 10 : 0; period_o = 0; high_o = 0; stuck_o = 1; valid_o pulse; state IDLE.
  - Timeout fires once, then not again until a new rise.
  - After IDLE, the next rise starts a fresh measurement with no capture.
- Timeout is not checked in DIVIDE. In DIVIDE, period_cnt is at most 4, which is below TIMEOUT.
- Reset mid-DIVIDE: division abandoned, outputs 0, no valid pulse.

Test Plan:
1. Drive iiitb_pwm_gen-style waveform, period 10, high 5, 20 periods -> from the 2nd rise on, valid_o once per period; period_o=10, high_o=5, duty_o=5; valid_o at C+5; overrun_o=0.
2. Period 100, high 37 -> duty_o=3 (floor 370/100). Then period 7, high 3 -> duty_o=4 (30/7), high_o=3, period_o=7.
3. Hold pwm_in=1 for TIMEOUT+10 cycles after a valid measurement -> exactly one valid_o; duty_o=10, stuck_o=1, period_o=0. Then resume period 10, high 2 -> first rise gives no valid_o; second rise gives duty_o=2, stuck_o=0.
4. Hold pwm_in=0 from reset for 2*TIMEOUT -> one valid_o, duty_o=0, stuck_o=1, no further pulses.
5. Period 4, high 2 -> overrun_o=1 and stays 1. Then switch to period 5, high 2 -> valid every period, duty_o=4, overrun_o still 1 until reset_n pulse.
6. Assert reset_n=0 asynchronously in cycle C+2 of a divide -> all outputs 0 immediately, no valid_o. After release, the first rise gives no capture.

Source files
------------

// File: rtl/iiitb_pwm_meas.sv
`default_nettype none
// ============================================================================
//  Module   : iiitb_pwm_meas
//  Brief    : PWM receiver; measures period/high time and reports duty in tenths
//  Revision : 1.0 - initial release
// ============================================================================
module iiitb_pwm_meas #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic [3:0]       duty_o,
    output logic             valid_o,
    output logic             stuck_o,
    output logic             overrun_o
);
    localparam int               DIV_W     = CNT_W + 4;
    localparam logic [1:0]       ST_IDLE    = 2'd0;
    localparam logic [1:0]       ST_MEASURE = 2'd1;
    localparam logic [1:0]       ST_DIVIDE  = 2'd2;
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    logic             r_s1, r_s2, r_s3;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_period_cnt, r_high_cnt;
    logic [CNT_W-1:0] r_period_cap, r_high_cap;
    logic [DIV_W-1:0] r_rem;
    logic [2:0]       r_quot;
    logic [1:0]       r_step;
    logic             r_timed_out;

    logic             w_rise;
    logic             w_timeout;
    logic             w_fits;
    logic [3:0]       w_duty;
    logic [DIV_W-1:0] w_trial;
    logic [DIV_W-1:0] w_dividend;

    assign w_rise     = r_s2 & ~r_s3;
    assign w_timeout  = (r_state != ST_DIVIDE) && !w_rise && !r_timed_out
                        && (r_period_cnt == C_TIMEOUT);
    // Restoring divide: try subtracting period << bit, MSB first.
    assign w_trial    = {4'b0000, r_period_cap} << r_step;
    assign w_fits     = (r_rem >= w_trial);
    assign w_duty     = {r_quot, w_fits};
    assign w_dividend = ({4'b0000, r_high_cnt} << 3) + ({4'b0000, r_high_cnt} << 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
        end else begin
            r_s1 <= pwm_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (w_rise) begin
                r_period_cnt <= C_CNT_ONE;
                r_high_cnt   <= C_CNT_ONE;
            end else begin
                if (r_period_cnt != C_CNT_MAX)
                    r_period_cnt <= r_period_cnt + C_CNT_ONE;
                if (r_s2 && (r_high_cnt != C_CNT_MAX))
                    r_high_cnt <= r_high_cnt + C_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_period_cap <= '0;
            r_high_cap   <= '0;
            r_rem        <= '0;
            r_quot       <= '0;
            r_step       <= '0;
            r_timed_out  <= 1'b0;
            period_o     <= '0;
            high_o       <= '0;
            duty_o       <= '0;
            valid_o      <= 1'b0;
            stuck_o      <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (w_rise)
                r_timed_out <= 1'b0;
            else if (w_timeout)
                r_timed_out <= 1'b1;

            if (w_timeout) begin
                period_o <= '0;
                high_o   <= '0;
                duty_o   <= r_s2 ? 4'd10 : 4'd0;
                stuck_o  <= 1'b1;
                valid_o  <= 1'b1;
                r_state  <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise)
                            r_state <= ST_MEASURE;
                    end
                    ST_MEASURE: begin
                        if (w_rise) begin
                            r_period_cap <= r_period_cnt;
                            r_high_cap   <= r_high_cnt;
                            r_rem        <= w_dividend;
                            r_quot       <= '0;
                            r_step       <= 2'd3;
                            r_state      <= ST_DIVIDE;
                        end
                    end
                    ST_DIVIDE: begin
                        // A rise here restarts the counters but its capture is lost.
                        if (w_rise)
                            overrun_o <= 1'b1;
                        if (w_fits)
                            r_rem <= r_rem - w_trial;
                        r_quot <= w_duty[2:0];
                        r_step <= r_step - 2'd1;
                        if (r_step == 2'd0) begin
                            period_o <= r_period_cap;
                            high_o   <= r_high_cap;
                            duty_o   <= w_duty;
                            valid_o  <= 1'b1;
                            stuck_o  <= 1'b0;
                            r_state  <= ST_MEASURE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_iiitb_pwm_meas.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iiitb_pwm_meas
//  Brief    : Scoreboard bench for iiitb_pwm_meas with an edge-timing reference
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iiitb_pwm_meas;
    localparam int CNT_W = 16;
    localparam int TO    = 200;
    localparam int INF   = 32'h3fff_ffff;

    typedef struct {
        int t;
        int period;
        int high;
        int duty;
        int stuck;
    } exp_t;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b1;
    logic             pwm_in  = 1'b0;
    logic [CNT_W-1:0] period_o, high_o;
    logic [3:0]       duty_o;
    logic             valid_o, stuck_o, overrun_o;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n      = 0;
    int   ov_time = INF;

    iiitb_pwm_meas #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pwm_in    (pwm_in),
        .period_o  (period_o),
        .high_o    (high_o),
        .duty_o    (duty_o),
        .valid_o   (valid_o),
        .stuck_o   (stuck_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, n);
        end
    endtask

    // Reference: works on pin samples (index = posedge number). A pin rise at
    // sample k is captured against the previous rise and reported 6 edges
    // later; a timeout at sample ref+TO is reported 2 edges later.
    initial begin
        int  ref_k, cap_k, ones;
        bit  prev_x, measuring, armed, x, rise;
        ref_k = 0; cap_k = -100; ones = 0;
        prev_x = 0; measuring = 0; armed = 1;
        forever begin
            @(posedge clk);
            n++;
            if (!reset_n) begin
                prev_x = 0; measuring = 0; armed = 1;
                ref_k = n - 1; cap_k = -100; ones = 0; ov_time = INF;
            end else begin
                x    = pwm_in;
                rise = x && !prev_x;
                if (!rise && armed && n == ref_k + TO) begin
                    sb.push_back('{n + 2, 0, 0, x ? 10 : 0, 1});
                    measuring = 0;
                    armed     = 0;
                end
                if (rise) begin
                    if (n <= cap_k + 4) begin
                        if (ov_time > n + 2) ov_time = n + 2;
                    end else if (measuring) begin
                        sb.push_back('{n + 6, n - ref_k, ones, (10 * ones) / (n - ref_k), 0});
                        cap_k = n;
                    end
                    measuring = 1;
                    armed     = 1;
                    ref_k     = n;
                    ones      = 1;
                end else begin
                    ones += int'(x);
                end
                prev_x = x;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && valid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid_o=1, expected none (cycle %0d)", n);
                end else begin
                    e = sb.pop_front();
                    chk("valid_time", n, e.t);
                    chk("period_o", int'(period_o), e.period);
                    chk("high_o", int'(high_o), e.high);
                    chk("duty_o", int'(duty_o), e.duty);
                    chk("stuck_o", int'(stuck_o), e.stuck);
                    chk("overrun_o", int'(overrun_o), (ov_time <= n) ? 1 : 0);
                end
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_period", int'(period_o), 0);
        chk("rst_high", int'(high_o), 0);
        chk("rst_duty", int'(duty_o), 0);
        chk("rst_flags", int'({valid_o, stuck_o, overrun_o}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_pwm(input int per, input int hi, input int cnt);
        for (int p = 0; p < cnt; p++)
            for (int c = 0; c < per; c++) begin
                @(negedge clk);
                pwm_in = (c < hi);
            end
    endtask

    task automatic hold(input bit b, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            pwm_in = b;
        end
    endtask

    task automatic drain(input string name);
        repeat (12) @(negedge clk);
        #1;
        chk(name, sb.size(), 0);
    endtask

    initial begin
        int per, hi;
        #2;
        do_reset();

        run_pwm(10, 5, 20);
        drain("drain_p10");

        run_pwm(100, 37, 4);
        run_pwm(7, 3, 6);
        drain("drain_p100_p7");

        for (int s = 0; s < 6; s++) begin
            per = $urandom_range(30, 5);
            hi  = $urandom_range(per - 1, 1);
            run_pwm(per, hi, $urandom_range(8, 4));
        end
        drain("drain_random");

        run_pwm(10, 5, 3);
        hold(1'b1, TO + 10);
        run_pwm(10, 2, 4);
        drain("drain_stuck_high");

        run_pwm(TO, 1, 3);
        run_pwm(TO + 1, 1, 2);
        drain("drain_timeout_edge");

        do_reset();
        hold(1'b0, 2 * TO);
        drain("drain_stuck_low");
        chk("stuck_low_flag", int'(stuck_o), 1);

        run_pwm(4, 2, 10);
        drain("drain_p4");
        chk("overrun_set", int'(overrun_o), 1);
        run_pwm(5, 2, 10);
        drain("drain_p5");
        chk("overrun_sticky", int'(overrun_o), 1);

        run_pwm(10, 5, 3);
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        do_reset();
        run_pwm(10, 5, 4);
        drain("drain_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
